// File: rtl/dmem_access_unit.sv
// Requester-side load/store controller for a word-wide data memory (async read, sync write).
// Optional alignment checking is enabled by defining DMEM_ACCESS_ALIGN_CHECK_EN.
module dmem_access_unit #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;

  logic f3_legal;
  logic misalign;
  logic out_of_range;
  logic req_err;

  // Merge store data into the word read back from memory.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] w;
    w = word;
    case (f3[1:0])
      2'b00: begin
        case (lo)
          2'b00:   w[7:0]   = wd[7:0];
          2'b01:   w[15:8]  = wd[7:0];
          2'b10:   w[23:16] = wd[7:0];
          default: w[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) w[31:16] = wd[15:0];
        else       w[15:0]  = wd[15:0];
      end
      default: w = wd;
    endcase
    return w;
  endfunction

  // Lane select plus sign/zero extension; funct3[2] selects the unsigned forms.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    if (req_write) f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                              (req_funct3 == 3'b010);
    else           f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                              (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                              (req_funct3 == 3'b101);
  end

`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign out_of_range = ({1'b0, req_addr} >= MEM_LIMIT);
  assign req_err      = !f3_legal || misalign || out_of_range;

  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    funct3_d   = funct3_q;
    write_d    = write_q;
    err_d      = err_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          write_d   = req_write;
          wdata_d   = req_wdata;
          err_d     = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            // Rejected requests leave the memory port untouched.
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_write && (req_funct3 == 3'b010)) begin
              mem_din_d = req_wdata;
              state_d   = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        data_d = mem_dout;
        if (write_q) begin
          mem_din_d = merge_store(mem_dout, funct3_q, addr_lo_q, wdata_q);
          state_d   = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_lo_q  <= 2'd0;
      funct3_q   <= 3'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      funct3_q   <= funct3_d;
      write_q    <= write_d;
      err_q      <= err_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ?
                      extend_load(data_q, funct3_q, addr_lo_q) : 32'd0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: table of requests against a word memory model,
// expected responses queued at issue and compared when resp_valid fires.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  dmem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  assign mem_dout = mem[mem_addr[15:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[15:2]] <= mem_din;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_din;
  } rec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Response monitor: every resp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
    if (mem_read && mem_write) chk("strobes_exclusive", 32'd1, 32'd0);
  end

  function automatic rec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input logic [31:0] din);
    rec_t r;
    r.wr = wr; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    r.exp_rdata = rdata; r.exp_err = err; r.exp_din = din;
    return r;
  endfunction

  task automatic do_req(input rec_t r);
    int lat, nrd, nwr, exp_lat, exp_rd, exp_wr;
    bit seen;
    exp_t e;
    exp_rd  = (!r.exp_err && !(r.wr && r.f3 == 3'b010)) ? 1 : 0;
    exp_wr  = (!r.exp_err && r.wr) ? 1 : 0;
    exp_lat = r.exp_err ? 1 : (r.wr && r.f3 != 3'b010) ? 3 : 2;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = r.wr; req_funct3 = r.f3;
    req_addr = r.addr; req_wdata = r.wdata;
    e.rdata = r.exp_rdata; e.err = r.exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        chk("write_addr", mem_addr, {r.addr[31:2], 2'b00});
        chk("write_din", mem_din, r.exp_din);
      end
      if (resp_valid) begin
        seen = 1;
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      end
    end
    chk("latency", lat, exp_lat);
    chk("mem_read_count", nrd, exp_rd);
    chk("mem_write_count", nwr, exp_wr);
  endtask

  rec_t tbl[$];

  initial begin
    logic [31:0] misal_rd;
    logic        misal_err;
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
    misal_rd = 32'h0; misal_err = 1'b1;
`else
    misal_rd = 32'hDE558001; misal_err = 1'b0;
`endif
    //           wr  f3      addr           wdata          rdata          err   din
    tbl.push_back(mk(1, 3'b010, 32'h10,    32'hDEADBEEF, 32'h0,         0, 32'hDEADBEEF)); // SW
    tbl.push_back(mk(0, 3'b010, 32'h10,    32'h0,        32'hDEADBEEF,  0, 32'h0));        // LW
    tbl.push_back(mk(1, 3'b000, 32'h12,    32'h55,       32'h0,         0, 32'hDE55BEEF)); // SB
    tbl.push_back(mk(0, 3'b100, 32'h12,    32'h0,        32'h00000055,  0, 32'h0));        // LBU
    tbl.push_back(mk(0, 3'b000, 32'h13,    32'h0,        32'hFFFFFFDE,  0, 32'h0));        // LB
    tbl.push_back(mk(1, 3'b001, 32'h10,    32'h8001,     32'h0,         0, 32'hDE558001)); // SH
    tbl.push_back(mk(0, 3'b001, 32'h10,    32'h0,        32'hFFFF8001,  0, 32'h0));        // LH
    tbl.push_back(mk(0, 3'b101, 32'h10,    32'h0,        32'h00008001,  0, 32'h0));        // LHU
    tbl.push_back(mk(0, 3'b101, 32'h12,    32'h0,        32'h0000DE55,  0, 32'h0));        // LHU hi
    tbl.push_back(mk(0, 3'b001, 32'h12,    32'h0,        32'hFFFFDE55,  0, 32'h0));        // LH hi
    tbl.push_back(mk(0, 3'b000, 32'h10,    32'h0,        32'h00000001,  0, 32'h0));        // LB b0
    tbl.push_back(mk(0, 3'b000, 32'h11,    32'h0,        32'hFFFFFF80,  0, 32'h0));        // LB b1
    tbl.push_back(mk(0, 3'b010, 32'h11,    32'h0,        misal_rd,      misal_err, 32'h0)); // LW misaligned
    tbl.push_back(mk(1, 3'b010, 32'h10000, 32'h11111111, 32'h0,         1, 32'h0));        // SW out of range
    tbl.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 32'h0,     32'h0,         1, 32'h0));        // LW far out of range
    tbl.push_back(mk(1, 3'b010, 32'hFFFC,  32'h12345678, 32'h0,         0, 32'h12345678)); // SW last word
    tbl.push_back(mk(0, 3'b010, 32'hFFFC,  32'h0,        32'h12345678,  0, 32'h0));        // LW last word
    tbl.push_back(mk(0, 3'b011, 32'h20,    32'h0,        32'h0,         1, 32'h0));        // illegal load f3
    tbl.push_back(mk(1, 3'b100, 32'h20,    32'hFF,       32'h0,         1, 32'h0));        // illegal store f3

    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) do_req(tbl[i]);
    chk("mem_word_0x10", mem[4], 32'hDE558001);
    chk("mem_word_0x20", mem[8], 32'h0);

    // Reset asserted while an SB sits in READ: abort with no write and no response.
    do_req(mk(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 32'hCAFEF00D));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sb_in_read", {31'd0, mem_read}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
    chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_din", mem_din, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_mem_unchanged", mem[8], 32'hCAFEF00D);
    do_req(mk(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 32'h0));

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Requester-side controller for the word-wide data memory. The data memory reads combinationally and writes synchronously on posedge.
- Sits between the CPU load/store path and the data memory port.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives mem_addr/mem_din/mem_read/mem_write.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores. Returns one response per request.

Parameters:
- MEM_BYTES, 65536, addressable bytes behind the port (16384 words); address >= MEM_BYTES is out of range.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/half used for SB/SH
- resp_valid  output  1  one-cycle pulse, response available
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request rejected (misaligned, out of range, or illegal funct3)
- mem_addr  output  32  word-aligned byte address to memory ({req_addr[31:2],2'b00})
- mem_din  output  32  write word to memory
- mem_read  output  1  read strobe
- mem_write  output  1  write strobe, sampled by memory at posedge
- mem_dout  input  32  memory read data, valid combinationally in the same cycle as mem_read

Behaviour:
- Reset (reset=0, async): state IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_err=0. mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
- Reset mid-operation aborts the operation immediately. mem_write drops before the next edge, so no memory write occurs. No response is issued.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, funct3, write and wdata.
  - Error check: err if any of:
    - funct3 is not in the legal set for the request type. Stores allow only 000/001/010.
    - Half-word access with addr[0]=1.
    - Word access with addr[1:0]!=0.
    - addr >= MEM_BYTES.
  - Next state: err -> RESP. SW -> WRITE. Load, SB, SH -> READ.
- READ:
  - Drive mem_read=1 and mem_addr.
  - Capture mem_dout into a data register at the edge.
  - Next state: load -> RESP. SB/SH -> WRITE.
- WRITE:
  - Drive mem_write=1, mem_addr, mem_din.
  - mem_din for SW: wdata.
  - mem_din for SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - mem_din for SH: captured word with half addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata, loads: selected lane. B/H sign-extended; BU/HU zero-extended; W full word.
  - resp_rdata is 0 for stores and errors.
  - resp_err held as registered.
  - Next state: IDLE.
- Strobes: mem_read/mem_write are decoded from state only; never both high. Outside READ/WRITE they are 0. mem_addr/mem_din hold their last values.
- req_ready=0 in READ/WRITE/RESP. Requests presented while not ready are ignored; the requester holds them.
- Latency, accept edge to resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP. Minimum 2 cycles between accepts.
- Errored requests never assert mem_read or mem_write.

Optional Feature:
- Macro: DMEM_ACCESS_ALIGN_CHECK_EN.
- Defined: misalignment produces resp_err=1 as above.
- Undefined:
  - No alignment check.
  - H/HU/SH use half addr[1]; W/SW ignore addr[1:0].
  - Only the illegal-funct3 and out-of-range conditions raise resp_err.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10: write cycle has mem_addr=0x10, mem_din=0xDEADBEEF; LW resp_rdata=0xDEADBEEF, resp_err=0, latency 2 each.
- Word 0x10=0xDEADBEEF, SB addr=0x12 wdata=0x55: READ then WRITE with mem_din=0xDE55BEEF; LBU 0x12 -> 0x00000055; LB 0x13 -> 0xFFFFFFDE.
- SH addr=0x10 wdata=0x8001 on 0xDE55BEEF: memory becomes 0xDE558001; LH 0x10 -> 0xFFFF8001; LHU 0x10 -> 0x00008001.
- LW addr=0x11 with macro defined: resp_valid one cycle after accept, resp_err=1, resp_rdata=0, no mem strobes. Same request without macro: reads word 0x10, resp_err=0.
- SW addr=0x10000 (MEM_BYTES=65536): resp_err=1, no mem_write.
- Reset pulled low during the SB READ state: outputs zero immediately; memory word unchanged; no resp_valid; after release, req_ready=1 and the next LW returns the original value.
